hm01b0_block_reader: RTL
========================

Name: hm01b0_block_reader

Overview:
- Read side of the hm01b0 stripe buffer.
- Once the ingester has filled one 8-row stripe (5 EBRs × 8 rows × 64 columns, double-buffered), this block reads that buffer back in 8x8 block order.
- Pixels stream out over a valid/ready interface to the JPEG DCT front end: 40 blocks per stripe, 64 pixels per block, row-major inside each block.

Parameters:
- NUM_EBRS, 5, EBRs per stripe buffer (320 px / 64 px per EBR).
- BLOCKS_PER_EBR, 8, 8x8 blocks per EBR (64 columns / 8).
- EBR_ROW_STRIDE, 64, address stride between pixel rows inside one EBR.

Ports:
- clock  input  1  system clock (single clock domain).
- reset  input  1  synchronous, active-high reset.
- stripe_start  input  1  one-cycle pulse: a stripe buffer is full.
- stripe_buffer  input  1  which buffer (0/1) is full; sampled with stripe_start.
- ebr_block_select  output  3  EBR index 0..NUM_EBRS-1 being read.
- ebr_buffer_select  output  1  buffer being read (latched stripe_buffer).
- ebr_raddr  output  9  EBR read address = row*64 + blk*8 + col.
- ebr_rden  output  1  read enable; data arrives on ebr_rdata exactly 1 cycle later.
- ebr_rdata  input  8  read data, muxed by top level using ebr_block_select/ebr_buffer_select.
- out_pixel  output  8  pixel value.
- out_valid  output  1  out_pixel and sideband fields are valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_block_index  output  6  block number in stripe, 0..39.
- out_pixel_index  output  6  index inside block, 0..63 (row*8+col).
- out_last_in_block  output  1  high with pixel index 63.
- out_last_in_stripe  output  1  high with block 39, pixel 63.
- busy  output  1  stripe read in progress.
- overrun  output  1  sticky: stripe_start arrived while busy.

Behaviour:
- Reset: every output is 0 (out_valid=0, busy=0, overrun=0, ebr_rden=0, ebr_raddr=0, out_* fields 0). Counters and skid buffer are emptied. Takes effect on the next clock edge regardless of state; an in-flight stripe is abandoned, with no partial completion.
- FSM states:
  - IDLE: busy=0. On stripe_start, latch stripe_buffer into ebr_buffer_select, clear counters, go to STREAM.
  - STREAM: busy=1. Issue reads in order: ebr 0..4, blk 0..7, row 0..7, col 0..7 (col fastest).
  - DRAIN: all 2560 reads issued. Wait until the skid buffer is empty and the last pixel has been accepted, then go to IDLE.
- Read issue: ebr_rden=1 in a cycle only if the skid buffer will have space for that data when it returns (occupancy + in-flight < 2). Address counters advance only on issued reads. When no read issues, address outputs hold.
- Latency: stripe_start at cycle N → first ebr_rden at N+1 → out_valid at N+2 at the earliest. With out_ready held high, one pixel per cycle and a full stripe (2560 pixels) completes by N+2561.
- Handshake:
  - out_valid, once asserted, stays high until accepted.
  - out_pixel and all sideband fields stay stable while out_valid && !out_ready.
  - No pixel is dropped or duplicated under any out_ready pattern.
- Sideband:
  - out_block_index = ebr*8 + blk, tracked alongside each read and carried through the skid buffer.
  - out_last_in_block and out_last_in_stripe are derived from the carried indices.
- stripe_start while busy (including the same cycle as the final acceptance): ignored, overrun set to 1 and held until reset. The current stripe continues unaffected.
- stripe_start in the cycle that DRAIN→IDLE completes (busy already 0): treated as a new stripe normally.
- Width rules:
  - ebr_raddr = {row[2:0], blk[2:0], col[2:0]}, which equals row*64+blk*8+col for 9 bits.
  - Counters wrap silently at their field width; terminal detection uses explicit compares (ebr==NUM_EBRS-1, etc.).

Decomposition:
- Shared package hm01b0_pkg: IMAGE_WIDTH=320, STRIPE_ROWS=8, NUM_EBRS, BLOCKS_PER_EBR, EBR_ADDR_W=9, BLOCKS_PER_STRIPE=40, and the FSM state encoding typedef (IDLE/STREAM/DRAIN).
- Sub-module: block_reader_skid_fifo, a 2-entry FIFO of {pixel, block_index, pixel_index}, 20 bits wide, with push/pop/occupancy. The top owns the FSM, address counters and overrun logic.

Test Plan:
- Counting pattern: preload EBR k buffer 0 with mem[a]=(a+k*3)&0xFF, pulse stripe_start with stripe_buffer=0, out_ready=1.
  - First beat: block 0, idx 0, pixel 0x00.
  - Beat 9: block 0, idx 9 (row 1, col 1), addr 65, pixel 0x41.
  - Block 8, idx 0 reads EBR1 addr 0: pixel 0x03.
  - Last beat: block 39, idx 63, addr 511, pixel (511+12)&0xFF=0x0B, last_in_stripe=1. 2560 beats total, done at N+2561.
- Backpressure: random out_ready at 30% duty. The output sequence must be identical to the previous case, with fields stable during stalls, and ebr_rden never issued when the FIFO plus in-flight count is already 2.
- Buffer select: buffer 1 filled with 0xA5 and buffer 0 with 0x00, stripe_buffer=1. Every beat is 0xA5 and ebr_buffer_select=1 throughout.
- Overrun: second stripe_start 100 cycles into a stripe. overrun goes to 1 and stays 1; the first stripe still delivers exactly 2560 beats; no second stripe runs.
- Reset mid-stripe: assert reset at beat 700 for 1 cycle. Next cycle all outputs are 0. A new stripe_start then yields block 0 idx 0 first and 2560 beats.
- Back-to-back: stripe_start issued on the cycle after busy falls. The new stripe begins with no overrun and no gap beyond the 2-cycle latency.

Source files
------------

// File: rtl/hm01b0_pkg.sv
// ============================================================================
//  Module      : hm01b0_pkg
//  Description : Shared geometry constants, FSM encoding and skid entry type
//                for the hm01b0 stripe buffer readers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package hm01b0_pkg;

    localparam int IMAGE_WIDTH       = 320;
    localparam int STRIPE_ROWS       = 8;
    localparam int NUM_EBRS          = 5;
    localparam int BLOCKS_PER_EBR    = 8;
    localparam int EBR_ROW_STRIDE    = 64;
    localparam int EBR_ADDR_W        = 9;
    localparam int BLOCKS_PER_STRIPE = NUM_EBRS * BLOCKS_PER_EBR;
    localparam int SKID_W            = 20;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic [7:0] pixel;
        logic [5:0] block_index;
        logic [5:0] pixel_index;
    } skid_entry_t;

endpackage

`default_nettype wire

// File: rtl/block_reader_skid_fifo.sv
// ============================================================================
//  Module      : block_reader_skid_fifo
//  Description : Two-entry FIFO holding returned pixels plus their indices.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module block_reader_skid_fifo
    import hm01b0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  skid_entry_t i_push_data,
    output skid_entry_t o_head_data,
    output logic [1:0]  o_occupancy
);

    skid_entry_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_occupancy = r_count;

endmodule

`default_nettype wire

// File: rtl/hm01b0_block_reader.sv
// ============================================================================
//  Module      : hm01b0_block_reader
//  Description : Reads a filled stripe buffer back in 8x8 block order and
//                streams the pixels over a valid/ready interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hm01b0_block_reader
    import hm01b0_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stripe_start,
    input  logic                  stripe_buffer,
    output logic [2:0]            ebr_block_select,
    output logic                  ebr_buffer_select,
    output logic [EBR_ADDR_W-1:0] ebr_raddr,
    output logic                  ebr_rden,
    input  logic [7:0]            ebr_rdata,
    output logic [7:0]            out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_block_index,
    output logic [5:0]            out_pixel_index,
    output logic                  out_last_in_block,
    output logic                  out_last_in_stripe,
    output logic                  busy,
    output logic                  overrun
);

    state_t      r_state;
    logic [2:0]  r_ebr;
    logic [2:0]  r_blk;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic        r_buffer;
    logic        r_overrun;
    logic        r_rd_pending;
    logic [5:0]  r_pend_blk;
    logic [5:0]  r_pend_pix;

    logic [1:0]  w_occ;
    logic [1:0]  w_outstanding;
    logic        w_issue;
    logic        w_last_read;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    skid_entry_t w_arrive;
    skid_entry_t w_head;
    skid_entry_t w_out;

    // A read may only issue if its data is guaranteed a FIFO slot on return.
    assign w_outstanding = w_occ + {1'b0, r_rd_pending};
    assign w_issue       = (r_state == ST_STREAM) && (w_outstanding < 2'd2);
    assign w_last_read   = (r_ebr == 3'(NUM_EBRS - 1)) && (r_blk == 3'(BLOCKS_PER_EBR - 1))
                         && (r_row == 3'd7) && (r_col == 3'd7);

    assign w_arrive = '{pixel: ebr_rdata, block_index: r_pend_blk, pixel_index: r_pend_pix};
    assign w_out    = (w_occ != 2'd0) ? w_head : w_arrive;

    assign out_valid = (w_occ != 2'd0) || r_rd_pending;
    assign w_accept  = out_valid && out_ready;
    // Returning data bypasses the FIFO only when nothing is queued ahead of it and it is taken now.
    assign w_push    = r_rd_pending && !((w_occ == 2'd0) && w_accept);
    assign w_pop     = w_accept && (w_occ != 2'd0);

    block_reader_skid_fifo u_skid (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_arrive),
        .o_head_data (w_head),
        .o_occupancy (w_occ)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ebr        <= 3'd0;
            r_blk        <= 3'd0;
            r_row        <= 3'd0;
            r_col        <= 3'd0;
            r_buffer     <= 1'b0;
            r_overrun    <= 1'b0;
            r_rd_pending <= 1'b0;
            r_pend_blk   <= 6'd0;
            r_pend_pix   <= 6'd0;
        end else begin
            r_rd_pending <= w_issue;
            if (stripe_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_issue) begin
                r_pend_blk <= {r_ebr, r_blk};
                r_pend_pix <= {r_row, r_col};
            end
            case (r_state)
                ST_IDLE: begin
                    if (stripe_start) begin
                        r_buffer <= stripe_buffer;
                        r_ebr    <= 3'd0;
                        r_blk    <= 3'd0;
                        r_row    <= 3'd0;
                        r_col    <= 3'd0;
                        r_state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        if (w_last_read) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_col <= r_col + 3'd1;
                            if (r_col == 3'd7) begin
                                r_row <= r_row + 3'd1;
                                if (r_row == 3'd7) begin
                                    r_blk <= r_blk + 3'd1;
                                    if (r_blk == 3'(BLOCKS_PER_EBR - 1)) begin
                                        r_ebr <= r_ebr + 3'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && out_last_in_stripe) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ebr_block_select   = r_ebr;
    assign ebr_buffer_select  = r_buffer;
    assign ebr_raddr          = {r_row, r_blk, r_col};
    assign ebr_rden           = w_issue;
    assign busy               = (r_state != ST_IDLE);
    assign overrun            = r_overrun;

    assign out_pixel          = out_valid ? w_out.pixel       : 8'd0;
    assign out_block_index    = out_valid ? w_out.block_index : 6'd0;
    assign out_pixel_index    = out_valid ? w_out.pixel_index : 6'd0;
    assign out_last_in_block  = out_valid && (w_out.pixel_index == 6'd63);
    assign out_last_in_stripe = out_valid && (w_out.pixel_index == 6'd63)
                              && (w_out.block_index == 6'(BLOCKS_PER_STRIPE - 1));

endmodule

`default_nettype wire
